mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32I five-stage pipeline, placed between the EX/MEM and MEM/WB pipeline registers. It takes the registered EX outputs, performs loads and stores over a request/acknowledge data-memory bus with byte-lane steering and sign extension, and stalls the front of the pipeline while an access is outstanding. It registers results toward WB and forwards the MEM-stage result to ID.

## Interface
- MAX_WAIT, 16: maximum request cycles without `dmem_ack` before the access is abandoned (range 1..255).

- clk  in  1  system clock; all registers update on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_in, iw_in  in  32 each  PC and instruction word from EX
- alu_in  in  32  ALU result; this is the effective address for loads and stores
- rs2_data_in  in  32  store data
- wb_reg_in  in  5  destination register
- wb_enable_in  in  1  register-write enable
- mem_we_in  in  1  store enable
- stall_out  out  1  hold EX/ID/IF; upstream keeps all `*_in` stable while high
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, `{alu_in[31:2],2'b00}`
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete this cycle
- dmem_rdata  in  32  read word; valid when `dmem_ack` is high
- df_mem_enable  out  1  forwarding enable to ID
- df_mem_reg  out  5  forwarding register
- df_mem_data  out  32  forwarding data
- pc_out, iw_out  out  32 each  to WB
- wb_data_out  out  32  writeback data
- wb_reg_out  out  5  to WB
- wb_enable_out  out  1  to WB
- misalign_out  out  1  the retired instruction was a misaligned access
- bus_err_out  out  1  the retired instruction timed out

## Operation
- **Classification.**
  - Load: `iw_in[6:0]==7'b0000011`.
  - Store: `mem_we_in==1` and opcode `7'b0100011`.
  - Anything else is a pass-through: `wb_data = alu_in`, no bus activity.
- **Access size** comes from `iw_in[14:12]`:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- **Misalignment.**
  - A halfword with `alu_in[0]=1` is misaligned.
  - A word with `alu_in[1:0]!=0` is misaligned.
  - A misaligned access gets no request and no stall.
  - It retires with `misalign_out=1` and `wb_enable_out=0`.
- **Store steering.**
  - SB: `be = 4'b0001 << alu_in[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = alu_in[1] ? 4'b1100 : 4'b0011`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = rs2`.
- **Loads.**
  - `dmem_be = 4'b1111`.
  - The byte or halfword is selected by `alu_in[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **FSM states.**
  - IDLE: an aligned memory op on the inputs drives `dmem_req=1` combinationally.
    - `dmem_ack` in the same cycle: complete; stay in IDLE.
    - No ack: `stall_out=1` and go to WAIT. The wait counter counts the request cycles and starts at 1.
  - WAIT: `dmem_req` stays high with the same address, byte enables and data; `stall_out=1`.
    - `dmem_ack`: complete, `stall_out=0` this cycle, go to IDLE.
    - The counter reaches MAX_WAIT with no ack: deassert the request, retire with `bus_err_out=1` and `wb_enable_out=0`, go to IDLE.
- **Stall rule.** `stall_out = mem_op & aligned & ~dmem_ack & ~timeout`.
- **WB register update.**
  - When `stall_out=0`, it captures `pc_in`, `iw_in`, `wb_data`, `wb_reg_in`, `wb_enable_in` (forced to 0 on error), `misalign_out` and `bus_err_out`.
  - When `stall_out=1`, it loads a bubble: every output 0.
- **Forwarding.**
  - `df_mem_reg = wb_reg_in`.
  - `df_mem_data` = the `wb_data` being captured.
  - `df_mem_enable = wb_enable_in & ~stall_out & ~misaligned & ~timeout`.
- `dmem_ack` while `dmem_req=0` is ignored.

## Timing
- **Reset.**
  - All registered outputs are 0, the FSM is in IDLE and the counter is 0.
  - `dmem_req` is gated to 0 while `reset_n` is low.
  - Assertion mid-access abandons the access immediately; no retry after release.
- **Latency.**
  - Pass-through, misaligned and zero-wait accesses: 1 cycle from inputs to WB outputs.
  - An ack on request cycle k: `stall_out` is high for k-1 cycles, and the WB outputs update at the edge ending cycle k.
- **Timeout.** Request high for exactly MAX_WAIT cycles, then the error retires at the edge ending cycle MAX_WAIT.
- **Back-to-back memory ops.** The second request starts the cycle after the first completes (IDLE re-entry); there is no dead cycle.

## Test plan
- **Pass-through.** ADDI, `alu_in=0x0000_0005`, `wb_reg_in=3` -> next edge `wb_data_out=5`, `wb_enable_out=1`; `dmem_req` never high.
- **Zero-wait LB sign-extend.** LB, `alu_in=0x102`, ack same cycle with `rdata=0x0080_0000` -> `dmem_be=4'hF`, `stall_out=0`, `wb_data_out=0xFFFF_FF80`. Repeat with LBU -> `0x0000_0080`.
- **Waited SH.** SH, `alu_in=0x206`, `rs2=0x1234_ABCD`, ack on the 3rd cycle -> `be=4'b1100`, `wdata=0xABCD_ABCD`, `stall_out` high 2 cycles, then a retire with `wb_enable_out=0`, preceded by 2 bubbles.
- **Misaligned LW.** LW, `alu_in=0x301` -> no request, `misalign_out=1`, `wb_enable_out=0`, `df_mem_enable=0`.
- **Timeout.** LW, `alu_in=0x400`, no ack, `MAX_WAIT=4` -> request high 4 cycles, then `bus_err_out=1`, `wb_enable_out=0`, FSM back in IDLE.
- **Reset mid-WAIT.** Pull `reset_n` low -> `dmem_req` and `stall_out` drop the same cycle and all outputs read 0. After release, a new LW with a zero-wait ack completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory-access stage: load/store over a req/ack data bus with byte-lane steering,
// sign extension, bounded wait with timeout, and registered results toward WB.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        mem_we_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam logic [8:0] MaxWait = 9'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_load, is_store, mem_op, misaligned, mem_access, timeout;
  logic [2:0]  funct3;
  logic [8:0]  req_cycle;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, wb_data;

  assign funct3   = iw_in[14:12];
  assign is_load  = (iw_in[6:0] == 7'b0000011);
  assign is_store = mem_we_in && (iw_in[6:0] == 7'b0100011);
  assign mem_op   = is_load || is_store;

  always_comb begin
    unique case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_op && alu_in[0];
      default: misaligned = mem_op && (alu_in[1:0] != 2'b00);
    endcase
  end

  assign mem_access = reset_n && mem_op && !misaligned;
  // Request-cycle number of the current cycle; the first request cycle is 1.
  assign req_cycle  = (state_q == StWait) ? {1'b0, cnt_q} + 9'd1 : 9'd1;
  assign timeout    = mem_access && !dmem_ack && (req_cycle >= MaxWait);
  assign stall_out  = mem_access && !dmem_ack && !timeout;

  assign dmem_req  = mem_access;
  assign dmem_we   = is_store;
  assign dmem_addr = {alu_in[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = rs2_data_in;
    if (is_store) begin
      unique case (funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << alu_in[1:0];
          dmem_wdata = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          dmem_be    = alu_in[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{rs2_data_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (alu_in[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = alu_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign wb_data       = is_load ? ld_data : alu_in;
  assign df_mem_reg    = wb_reg_in;
  assign df_mem_data   = wb_data;
  assign df_mem_enable = wb_enable_in && !stall_out && !misaligned && !timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    unique case (state_q)
      StIdle: begin
        if (stall_out) begin
          state_d = StWait;
          cnt_d   = 8'd1;
        end
      end
      StWait: begin
        if (stall_out) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out        <= 32'h0;
      iw_out        <= 32'h0;
      wb_data_out   <= 32'h0;
      wb_reg_out    <= 5'h0;
      wb_enable_out <= 1'b0;
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end else if (stall_out) begin
      pc_out        <= 32'h0;
      iw_out        <= 32'h0;
      wb_data_out   <= 32'h0;
      wb_reg_out    <= 5'h0;
      wb_enable_out <= 1'b0;
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      pc_out        <= pc_in;
      iw_out        <= iw_in;
      wb_data_out   <= wb_data;
      wb_reg_out    <= wb_reg_in;
      wb_enable_out <= wb_enable_in && !misaligned && !timeout;
      misalign_out  <= misaligned;
      bus_err_out   <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with a short wait limit.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_enable_in, mem_we_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data, pc_out, iw_out, wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_enable_out, misalign_out, bus_err_out;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_in         (pc_in),
    .iw_in         (iw_in),
    .alu_in        (alu_in),
    .rs2_data_in   (rs2_data_in),
    .wb_reg_in     (wb_reg_in),
    .wb_enable_in  (wb_enable_in),
    .mem_we_in     (mem_we_in),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .df_mem_enable (df_mem_enable),
    .df_mem_reg    (df_mem_reg),
    .df_mem_data   (df_mem_data),
    .pc_out        (pc_out),
    .iw_out        (iw_out),
    .wb_data_out   (wb_data_out),
    .wb_reg_out    (wb_reg_out),
    .wb_enable_out (wb_enable_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_iw(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'd0, op};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic we, input logic ack, input logic [31:0] rdata);
    pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; wb_reg_in = rd;
    wb_enable_in = wen; mem_we_in = we; dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(32'h40, mk_iw(3'b010, OpLoad), 32'h100, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL reset_req req=%b stall=%b want 0 0", dmem_req, stall_out);
    end
    after_edge();
    checks++;
    if ({pc_out, iw_out, wb_data_out, wb_reg_out, wb_enable_out, misalign_out, bus_err_out}
        !== '0) begin
      errors++; $display("FAIL reset_outs pc=%h iw=%h data=%h en=%b want all 0",
                         pc_out, iw_out, wb_data_out, wb_enable_out);
    end
    @(negedge clk);
    drive(32'h0, mk_iw(3'b000, OpImm), 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    drive(32'h80, mk_iw(3'b000, OpImm), 32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || df_mem_enable !== 1'b1 ||
        df_mem_data !== 32'h5 || df_mem_reg !== 5'd3) begin
      errors++; $display("FAIL pass_comb req=%b stall=%b dfen=%b dfdata=%h want 0 0 1 5",
                         dmem_req, stall_out, df_mem_enable, df_mem_data);
    end
    after_edge();
    checks++;
    if (wb_data_out !== 32'h5 || wb_enable_out !== 1'b1 || wb_reg_out !== 5'd3 ||
        pc_out !== 32'h80) begin
      errors++; $display("FAIL pass_wb data=%h en=%b reg=%0d pc=%h want 5 1 3 80",
                         wb_data_out, wb_enable_out, wb_reg_out, pc_out);
    end
  endtask

  task automatic test_load_zero_wait();
    @(negedge clk);
    drive(32'h84, mk_iw(3'b000, OpLoad), 32'h102, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0080_0000);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'hF || stall_out !== 1'b0 ||
        dmem_addr !== 32'h100) begin
      errors++; $display("FAIL lb_bus req=%b we=%b be=%h stall=%b addr=%h want 1 0 f 0 100",
                         dmem_req, dmem_we, dmem_be, stall_out, dmem_addr);
    end
    after_edge();
    checks++;
    if (wb_data_out !== 32'hFFFF_FF80 || wb_enable_out !== 1'b1) begin
      errors++; $display("FAIL lb_data data=%h en=%b want ffffff80 1", wb_data_out, wb_enable_out);
    end
    @(negedge clk);
    iw_in = mk_iw(3'b100, OpLoad);
    after_edge();
    checks++;
    if (wb_data_out !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_data data=%h want 00000080", wb_data_out);
    end
  endtask

  task automatic test_waited_store();
    int stalls = 0;
    logic [31:0] sh_iw;
    sh_iw = mk_iw(3'b001, OpStore);
    @(negedge clk);
    drive(32'h88, sh_iw, 32'h206, 32'h1234_ABCD, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        @(negedge clk);
        dmem_ack = 1'b1;
      end else if (c > 1) begin
        @(negedge clk);
      end
      #1;
      if (stall_out === 1'b1) stalls++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
          dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h204) begin
        errors++; $display("FAIL sh_bus cyc=%0d req=%b we=%b be=%b wdata=%h addr=%h", c,
                           dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      end
      after_edge();
      checks++;
      if (c < 3 && (iw_out !== 32'h0 || pc_out !== 32'h0 || wb_enable_out !== 1'b0)) begin
        errors++; $display("FAIL sh_bubble cyc=%0d iw=%h pc=%h want 0 0", c, iw_out, pc_out);
      end else if (c == 3 && (iw_out !== sh_iw || pc_out !== 32'h88 || wb_enable_out !== 1'b0 ||
                              bus_err_out !== 1'b0)) begin
        errors++; $display("FAIL sh_retire iw=%h pc=%h en=%b err=%b want %h 88 0 0",
                           iw_out, pc_out, wb_enable_out, bus_err_out, sh_iw);
      end
    end
    checks++;
    if (stalls != 2) begin
      errors++; $display("FAIL sh_stall_cycles got %0d want 2", stalls);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive(32'h8C, mk_iw(3'b010, OpLoad), 32'h301, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || df_mem_enable !== 1'b0) begin
      errors++; $display("FAIL mis_comb req=%b stall=%b dfen=%b want 0 0 0",
                         dmem_req, stall_out, df_mem_enable);
    end
    after_edge();
    checks++;
    if (misalign_out !== 1'b1 || wb_enable_out !== 1'b0 || bus_err_out !== 1'b0) begin
      errors++; $display("FAIL mis_wb mis=%b en=%b err=%b want 1 0 0",
                         misalign_out, wb_enable_out, bus_err_out);
    end
  endtask

  task automatic test_timeout();
    int reqs = 0;
    @(negedge clk);
    drive(32'h90, mk_iw(3'b010, OpLoad), 32'h400, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (dmem_req === 1'b1) reqs++;
      checks++;
      if (stall_out !== (c < 4)) begin
        errors++; $display("FAIL to_stall cyc=%0d got %b want %b", c, stall_out, c < 4);
      end
      after_edge();
    end
    checks++;
    if (reqs != 4) begin
      errors++; $display("FAIL to_req_cycles got %0d want 4", reqs);
    end
    checks++;
    if (bus_err_out !== 1'b1 || wb_enable_out !== 1'b0 || pc_out !== 32'h90) begin
      errors++; $display("FAIL to_retire err=%b en=%b pc=%h want 1 0 90",
                         bus_err_out, wb_enable_out, pc_out);
    end
    // IDLE again: a fresh request with no ack must stall on its first cycle.
    @(negedge clk);
    drive(32'h94, mk_iw(3'b010, OpLoad), 32'h404, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
      errors++; $display("FAIL to_idle req=%b stall=%b want 1 1", dmem_req, stall_out);
    end
    after_edge();
  endtask

  task automatic test_back_to_back();
    // Ack the pending LW at 0x404 on its second request cycle.
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (stall_out !== 1'b0 || df_mem_enable !== 1'b1 || df_mem_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_first stall=%b dfen=%b dfdata=%h want 0 1 cafef00d",
                         stall_out, df_mem_enable, df_mem_data);
    end
    after_edge();
    checks++;
    if (wb_data_out !== 32'hCAFE_F00D || wb_enable_out !== 1'b1) begin
      errors++; $display("FAIL b2b_first_wb data=%h en=%b", wb_data_out, wb_enable_out);
    end
    @(negedge clk);
    drive(32'h98, mk_iw(3'b001, OpLoad), 32'h502, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h8001_0000);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b0) begin
      errors++; $display("FAIL b2b_second req=%b stall=%b want 1 0", dmem_req, stall_out);
    end
    after_edge();
    checks++;
    if (wb_data_out !== 32'hFFFF_8001 || wb_reg_out !== 5'd7) begin
      errors++; $display("FAIL lh_data data=%h reg=%0d want ffff8001 7", wb_data_out, wb_reg_out);
    end
    @(negedge clk);
    iw_in = mk_iw(3'b101, OpLoad);
    after_edge();
    checks++;
    if (wb_data_out !== 32'h0000_8001) begin
      errors++; $display("FAIL lhu_data data=%h want 00008001", wb_data_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(32'hA0, mk_iw(3'b010, OpLoad), 32'h600, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
    after_edge();
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b1 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre stall=%b req=%b want 1 1", stall_out, dmem_req);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_data_out !== 32'h0 || iw_out !== 32'h0 ||
        bus_err_out !== 1'b0) begin
      errors++; $display("FAIL rst_wait req=%b stall=%b data=%h iw=%h want all 0",
                         dmem_req, stall_out, wb_data_out, iw_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'hA4, mk_iw(3'b010, OpLoad), 32'h700, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'h700) begin
      errors++; $display("FAIL rst_after stall=%b req=%b addr=%h", stall_out, dmem_req, dmem_addr);
    end
    after_edge();
    checks++;
    if (wb_data_out !== 32'hDEAD_BEEF || wb_enable_out !== 1'b1 || wb_reg_out !== 5'd9) begin
      errors++; $display("FAIL rst_after_wb data=%h en=%b reg=%0d", wb_data_out, wb_enable_out,
                         wb_reg_out);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_pass_through();
    test_load_zero_wait();
    test_waited_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
